div_operand_sequencer: RTL and testbench
========================================

# div_operand_sequencer

Front-end stage for the 4-bit restoring divider. Synchronises an active-low push-button and captures switch operands on a start request. Drives the divider's operand inputs and a one-cycle `go` pulse, waits a fixed latency, then captures and holds quotient/remainder with a `valid` flag for the display logic.

## Interface
Parameters:
- `WIDTH`, 4: operand/result width.
- `RESULT_LAT`, 10: cycles from the `go` cycle to the cycle the divider result is sampled (≥1).

Ports:
- `clk`, input, 1: clock.
- `resetn`, input, 1: reset, synchronous, active-low.
- `key_n`, input, 1: asynchronous start button, active-low.
- `sw_divisor`, input, WIDTH: divisor switches.
- `sw_dividend`, input, WIDTH: dividend switches.
- `op_divisor`, output, WIDTH: divisor to divider.
- `op_dividend`, output, WIDTH: dividend to divider.
- `go`, output, 1: start pulse to divider.
- `div_quotient`, input, WIDTH: quotient from divider.
- `div_remainder`, input, WIDTH: remainder from divider.
- `quotient`, output, WIDTH: held quotient.
- `remainder`, output, WIDTH: held remainder.
- `valid`, output, 1: held result is current.
- `busy`, output, 1: operation in flight.
- `div_by_zero`, output, 1: last result was a zero-divisor case.

## Operation
- Input conditioning:
  - `key_n` passes through a 2-flop synchroniser, then an edge register.
  - `start` = synchronised level low AND previous synchronised level high, i.e. a falling edge of `key_n`, one cycle wide.
- FSM states:
  - IDLE: on `start`, latch `sw_divisor`/`sw_dividend` into operand registers and go to ISSUE; otherwise stay.
  - ISSUE: `go`=1 for exactly this cycle; clear `valid` and `div_by_zero`; load the wait counter with RESULT_LAT-1; go to WAIT.
  - WAIT: decrement the counter; when it equals 0, go to CAPTURE.
  - CAPTURE: register `div_quotient`/`div_remainder` into `quotient`/`remainder`; set `valid`=1; go to IDLE.
- `busy`=1 in ISSUE, WAIT and CAPTURE.
- `op_divisor`/`op_dividend` change only on an accepted `start`. They are held stable through the whole operation and afterwards.
- `start` events outside IDLE are discarded, not queued.
- `valid` remains 1 until the next accepted operation reaches ISSUE.
- Divide-by-zero:
  - With the macro: handled as in Configuration.
  - Without the macro: the operation runs normally and whatever the divider returns is captured.

## Timing
- Reset values, all outputs: `op_*`=0, `go`=0, `quotient`=0, `remainder`=0, `valid`=0, `busy`=0, `div_by_zero`=0. State is IDLE and the synchroniser flops are 1 (released button).
- Key-fall to `start`: 2–3 cycles, depending on metastability alignment.
- `start` at cycle N gives:
  - `go` at N+1;
  - divider outputs sampled in CAPTURE at N+1+RESULT_LAT;
  - `valid`/`quotient`/`remainder` updated at N+2+RESULT_LAT.
- RESULT_LAT=1 skips WAIT (counter load 0 goes straight to CAPTURE).
- Reset asserted in any state: next edge returns all registers to reset values. `go` never stays asserted past the reset edge, and a partial result is never captured.
- `start` in the same cycle that CAPTURE returns to IDLE is ignored. The earliest accepted `start` is the first cycle in IDLE.

## Configuration
- Macro `DIV_ZERO_CHECK_EN`.
- Defined: in IDLE on `start` with `sw_divisor`==0:
  - the block skips ISSUE and WAIT, and `go` is never pulsed;
  - the next cycle is CAPTURE, loading `quotient`=all ones, `remainder`=dividend, `div_by_zero`=1, `valid`=1.
- Undefined: no zero-divisor detection logic; `div_by_zero` is tied to 0.

## Structure
- Shared package `div_pkg` holds:
  - the FSM state enum (IDLE, ISSUE, WAIT, CAPTURE);
  - default `WIDTH`;
  - default `RESULT_LAT`;
  - the all-ones quotient constant used for divide-by-zero.
- One sub-module `key_sync_edge`: 2-flop synchroniser plus falling-edge detector producing `start`. Its reset is synchronous, active-low, and drives the flops to 1.

## Test plan
- Reset, then press with divisor=4, dividend=13 → one `go` pulse; after RESULT_LAT the block shows `quotient`=3, `remainder`=1, `valid`=1, `busy`=0.
- Divisor=1, dividend=15 → `quotient`=15, `remainder`=0. Follow with divisor=5, dividend=0 → `quotient`=0, `remainder`=0; `valid` drops at ISSUE and rises at CAPTURE.
- Second key press during WAIT → no extra `go`; the first result is unchanged. A press after return to IDLE is accepted.
- Switches changed during WAIT → `op_divisor`/`op_dividend` unchanged until the next accepted `start`.
- With `DIV_ZERO_CHECK_EN`, divisor=0, dividend=7 → no `go`; `quotient`=4'hF, `remainder`=7, `div_by_zero`=1. Without the macro → `go` is issued and `div_by_zero` stays 0.
- `resetn` low during WAIT → all outputs return to 0 on the next edge; no capture occurs after release.

Source files
------------

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and defaults for the divider operand sequencer
package div_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  localparam int DEF_WIDTH      = 4;
  localparam int DEF_RESULT_LAT = 10;

  // Quotient reported for a zero divisor; sliced to the operand width at use.
  localparam logic [31:0] QUOT_ALL_ONES = '1;

endpackage

// File: rtl/key_sync_edge.sv
// rtl/key_sync_edge.sv - push-button synchroniser with one-cycle falling-edge start
module key_sync_edge (
  input  logic clk,
  input  logic resetn,
  input  logic key_n_i,
  output logic start_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // Two-flop synchroniser and edge register; reset level is the released button.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Press is a high-to-low transition of the synchronised level.
  always_comb begin
    start_o = prev_q & ~sync2_q;
  end

endmodule

// File: rtl/div_operand_sequencer.sv
// rtl/div_operand_sequencer.sv - captures operands, pulses go, holds divider result (option: DIV_ZERO_CHECK_EN)
module div_operand_sequencer
  import div_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int RESULT_LAT = DEF_RESULT_LAT
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             key_n,
  input  logic [WIDTH-1:0] sw_divisor,
  input  logic [WIDTH-1:0] sw_dividend,
  output logic [WIDTH-1:0] op_divisor,
  output logic [WIDTH-1:0] op_dividend,
  output logic             go,
  input  logic [WIDTH-1:0] div_quotient,
  input  logic [WIDTH-1:0] div_remainder,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             valid,
  output logic             busy,
  output logic             div_by_zero
);

  // Counter holds RESULT_LAT-1 at most.
  localparam int               CNT_W    = (RESULT_LAT > 1) ? $clog2(RESULT_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RESULT_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] op_divisor_q, op_divisor_d;
  logic [WIDTH-1:0] op_dividend_q, op_dividend_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             valid_q, valid_d;
  logic             start;

`ifdef DIV_ZERO_CHECK_EN
  logic dz_q, dz_d;
  logic dz_pend_q, dz_pend_d;
`endif

  key_sync_edge u_key_sync_edge (
    .clk     (clk),
    .resetn  (resetn),
    .key_n_i (key_n),
    .start_o (start)
  );

  // State, operand and result registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      op_divisor_q  <= '0;
      op_dividend_q <= '0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      valid_q       <= 1'b0;
`ifdef DIV_ZERO_CHECK_EN
      dz_q          <= 1'b0;
      dz_pend_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      op_divisor_q  <= op_divisor_d;
      op_dividend_q <= op_dividend_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      valid_q       <= valid_d;
`ifdef DIV_ZERO_CHECK_EN
      dz_q          <= dz_d;
      dz_pend_q     <= dz_pend_d;
`endif
    end
  end

  // Next-state logic; presses outside IDLE fall through the default and are dropped.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    op_divisor_d  = op_divisor_q;
    op_dividend_d = op_dividend_q;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    valid_d       = valid_q;
`ifdef DIV_ZERO_CHECK_EN
    dz_d          = dz_q;
    dz_pend_d     = dz_pend_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          op_divisor_d  = sw_divisor;
          op_dividend_d = sw_dividend;
`ifdef DIV_ZERO_CHECK_EN
          if (sw_divisor == '0) begin
            dz_pend_d = 1'b1;
            state_d   = CAPTURE;
          end else begin
            state_d = ISSUE;
          end
`else
          state_d = ISSUE;
`endif
        end
      end
      ISSUE: begin
        valid_d = 1'b0;
`ifdef DIV_ZERO_CHECK_EN
        dz_d    = 1'b0;
`endif
        cnt_d   = CNT_LOAD;
        state_d = (RESULT_LAT == 1) ? CAPTURE : WAIT;
      end
      WAIT: begin
        // Leaving on the final decrement makes CAPTURE land RESULT_LAT cycles after go.
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        quotient_d  = div_quotient;
        remainder_d = div_remainder;
        valid_d     = 1'b1;
`ifdef DIV_ZERO_CHECK_EN
        if (dz_pend_q) begin
          quotient_d  = QUOT_ALL_ONES[WIDTH-1:0];
          remainder_d = op_dividend_q;
          dz_d        = 1'b1;
          dz_pend_d   = 1'b0;
        end
`endif
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state only, so reset clears go on the same edge.
  always_comb begin
    op_divisor  = op_divisor_q;
    op_dividend = op_dividend_q;
    go          = (state_q == ISSUE);
    busy        = (state_q != IDLE);
    quotient    = quotient_q;
    remainder   = remainder_q;
    valid       = valid_q;
`ifdef DIV_ZERO_CHECK_EN
    div_by_zero = dz_q;
`else
    div_by_zero = 1'b0;
`endif
  end

endmodule

// File: tb/tb_div_operand_sequencer.sv
// tb/tb_div_operand_sequencer.sv - directed self-checking bench for div_operand_sequencer
module tb_div_operand_sequencer;

  localparam int W   = 4;
  localparam int LAT = 10;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         key_n = 1'b1;
  logic [W-1:0] sw_divisor = '0;
  logic [W-1:0] sw_dividend = '0;
  logic [W-1:0] op_divisor, op_dividend;
  logic [W-1:0] div_quotient, div_remainder;
  logic [W-1:0] quotient, remainder;
  logic         go, valid, busy, div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  int   cyc            = 0;
  int   go_cnt         = 0;
  int   go_cyc         = -10;
  int   valid_rise_cyc = -10;
  logic valid_prev     = 1'b0;
  logic valid_after_go = 1'b1;
  int   since_go;
  logic [W-1:0] true_q, true_r;

  always #5 clk = ~clk;

  div_operand_sequencer #(.WIDTH(W), .RESULT_LAT(LAT)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .key_n         (key_n),
    .sw_divisor    (sw_divisor),
    .sw_dividend   (sw_dividend),
    .op_divisor    (op_divisor),
    .op_dividend   (op_dividend),
    .go            (go),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder),
    .quotient      (quotient),
    .remainder     (remainder),
    .valid         (valid),
    .busy          (busy),
    .div_by_zero   (div_by_zero)
  );

  // Divider stand-in: correct only in the cycle exactly LAT after go, inverted otherwise.
  always_comb begin
    if (op_divisor == '0) begin
      true_q = '1;
      true_r = op_dividend;
    end else begin
      true_q = op_dividend / op_divisor;
      true_r = op_dividend % op_divisor;
    end
  end
  assign div_quotient  = (since_go == LAT) ? true_q : ~true_q;
  assign div_remainder = (since_go == LAT) ? true_r : ~true_r;

  always @(posedge clk) begin
    if (!resetn)                          since_go <= 0;
    else if (go)                          since_go <= 1;
    else if (since_go > 0 && since_go < 100) since_go <= since_go + 1;
  end

  // Event monitor, sampled just after each active edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (go) begin
      go_cnt++;
      go_cyc = cyc;
    end
    if (cyc == go_cyc + 1) valid_after_go = valid;
    if (valid && !valid_prev) valid_rise_cyc = cyc;
    valid_prev = valid;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic press();
    @(negedge clk) key_n = 1'b0;
    repeat (4) @(negedge clk);
    key_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!(valid && !busy) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, (n < 60), 1);
  endtask

  task automatic run_op(input logic [W-1:0] dv, input logic [W-1:0] dd,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input string tag);
    int g0 = go_cnt;
    sw_divisor  = dv;
    sw_dividend = dd;
    press();
    wait_done(tag);
    check({tag, "_go_count"}, go_cnt - g0, 1);
    check({tag, "_op_divisor"}, op_divisor, dv);
    check({tag, "_op_dividend"}, op_dividend, dd);
    check({tag, "_valid_drop"}, valid_after_go, 0);
    check({tag, "_latency"}, valid_rise_cyc - go_cyc, LAT + 1);
    check({tag, "_quotient"}, quotient, eq);
    check({tag, "_remainder"}, remainder, er);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_dbz"}, div_by_zero, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_op_divisor", op_divisor, 0);
    check("rst_op_dividend", op_dividend, 0);
    check("rst_go", go, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_dbz", div_by_zero, 0);
    resetn = 1'b1;
    repeat (3) @(negedge clk);

    // Basic operations
    run_op(4'd4, 4'd13, 4'd3, 4'd1, "op_4_13");
    run_op(4'd1, 4'd15, 4'd15, 4'd0, "op_1_15");
    run_op(4'd5, 4'd0, 4'd0, 4'd0, "op_5_0");

    // Second press and switch changes while in WAIT
    g0 = go_cnt;
    sw_divisor  = 4'd4;
    sw_dividend = 4'd13;
    press();
    check("wait_busy", busy, 1);
    sw_divisor  = 4'd9;
    sw_dividend = 4'd2;
    @(negedge clk) key_n = 1'b0;
    repeat (3) @(negedge clk);
    check("wait_op_divisor", op_divisor, 4);
    check("wait_op_dividend", op_dividend, 13);
    key_n = 1'b1;
    wait_done("dbl");
    check("dbl_go_count", go_cnt - g0, 1);
    check("dbl_quotient", quotient, 3);
    check("dbl_remainder", remainder, 1);
    check("dbl_op_divisor", op_divisor, 4);
    repeat (4) @(negedge clk);
    check("dbl_late_go_count", go_cnt - g0, 1);
    run_op(4'd9, 4'd2, 4'd0, 4'd2, "after_idle");

    // Zero divisor
`ifdef DIV_ZERO_CHECK_EN
    g0 = go_cnt;
    sw_divisor  = 4'd0;
    sw_dividend = 4'd7;
    press();
    wait_done("dz");
    check("dz_go_count", go_cnt - g0, 0);
    check("dz_quotient", quotient, 4'hF);
    check("dz_remainder", remainder, 7);
    check("dz_flag", div_by_zero, 1);
    check("dz_valid", valid, 1);
`else
    run_op(4'd0, 4'd7, 4'hF, 4'd7, "dz");
`endif

    // Reset during WAIT
    g0 = go_cnt;
    sw_divisor  = 4'd3;
    sw_dividend = 4'd11;
    press();
    check("mid_busy", busy, 1);
    @(negedge clk) resetn = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_go", go, 0);
    check("mid_rst_valid", valid, 0);
    check("mid_rst_quotient", quotient, 0);
    check("mid_rst_remainder", remainder, 0);
    check("mid_rst_op_divisor", op_divisor, 0);
    check("mid_rst_op_dividend", op_dividend, 0);
    check("mid_rst_dbz", div_by_zero, 0);
    resetn = 1'b1;
    repeat (25) @(negedge clk);
    check("post_rst_valid", valid, 0);
    check("post_rst_quotient", quotient, 0);
    check("post_rst_remainder", remainder, 0);
    check("post_rst_go_count", go_cnt - g0, 1);
    check("post_rst_busy", busy, 0);

    // Normal operation resumes after reset
    run_op(4'd3, 4'd11, 4'd3, 4'd2, "op_3_11");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
